// File: rtl/trap_sequencer.sv
// trap_sequencer: trap entry / mret exit sequencer with CSR strobes and fetch redirect.
// Define TRAP_SEQ_DOUBLE_FAULT_EN to lock up on a trap raised inside a handler.
module trap_sequencer #(
  parameter logic [31:0] MTVEC_BASE = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        initiate_illinst,
  input  logic        initiate_misaligned,
  input  logic        misaligned_is_fetch,
  input  logic        misaligned_is_store,
  input  logic        epc_from_xb,
  input  logic [31:0] FD_pc,
  input  logic [31:0] XB_pc,
  input  logic [31:0] FD_inst,
  input  logic [31:0] FD_mem_addr,
  input  logic        mret_req,
  input  logic [31:0] mepc_in,
  input  logic        fetch_ack,
  output logic        flush_fd,
  output logic        flush_xb,
  output logic        stall_fetch,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        cause_we,
  output logic [31:0] cause_out,
  output logic        tval_we,
  output logic [31:0] tval_out,
  output logic        in_handler,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT,
    LOCKED
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        trap_req;
  logic        lock_trap;
  logic        take_trap;
  logic        take_mret;
  logic        sel_ill;
  logic        sel_fetch;
  logic        sel_store;
  logic        sel_load;
  logic [31:0] epc_pc;
  logic [31:0] cause_code;
  logic        flush_d;
  logic        stall_d;
  logic        rv_d;
  logic        we_d;
  logic [31:0] rpc_d;
  logic [31:0] epc_d;
  logic [31:0] cause_d;
  logic [31:0] tval_d;
  logic        inh_d;
  logic        halted_d;

  assign trap_req = initiate_illinst | initiate_misaligned;

`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
  assign lock_trap = in_handler;
  assign halted_d  = (state_d == LOCKED);
`else
  assign lock_trap = 1'b0;
  assign halted_d  = 1'b0;
`endif

  assign take_trap = (state_q == IDLE) & trap_req & ~lock_trap;
  assign take_mret = (state_q == IDLE) & ~trap_req & mret_req;

  // One-hot cause select; illegal beats misaligned, fetch beats store/load
  assign sel_ill   = initiate_illinst;
  assign sel_fetch = ~initiate_illinst & misaligned_is_fetch;
  assign sel_store = ~initiate_illinst & ~misaligned_is_fetch
                   & misaligned_is_store;
  assign sel_load  = ~initiate_illinst & ~misaligned_is_fetch
                   & ~misaligned_is_store;

  always_comb begin
    cause_code = 32'd4;
    unique case (1'b1)
      sel_ill:   cause_code = 32'd2;
      sel_fetch: cause_code = 32'd0;
      sel_store: cause_code = 32'd6;
      sel_load:  cause_code = 32'd4;
      default:   cause_code = 32'd4;
    endcase
  end

  assign epc_pc = epc_from_xb ? XB_pc : FD_pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trap_req)
          state_d = lock_trap ? LOCKED : FLUSH;
        else if (mret_req)
          state_d = FLUSH;
      end
      FLUSH:    state_d = REDIRECT;
      REDIRECT: if (fetch_ack) state_d = IDLE;
      LOCKED:   state_d = LOCKED;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_d = (state_d == FLUSH) | (state_d == LOCKED);
    stall_d = (state_d != IDLE);
    rv_d    = (state_d == REDIRECT);
    we_d    = take_trap;
    rpc_d   = redirect_pc;
    epc_d   = epc_out;
    cause_d = cause_out;
    tval_d  = tval_out;
    inh_d   = in_handler;
    if (take_trap) begin
      rpc_d   = MTVEC_BASE;
      epc_d   = epc_pc & ~32'h3;
      cause_d = cause_code;
      tval_d  = initiate_illinst ? FD_inst : FD_mem_addr;
      inh_d   = 1'b1;
    end else if (take_mret) begin
      rpc_d   = mepc_in & ~32'h3;
      inh_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q        <= IDLE;
      flush_fd       <= 1'b0;
      flush_xb       <= 1'b0;
      stall_fetch    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      epc_we         <= 1'b0;
      epc_out        <= 32'h0;
      cause_we       <= 1'b0;
      cause_out      <= 32'h0;
      tval_we        <= 1'b0;
      tval_out       <= 32'h0;
      in_handler     <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_fd       <= flush_d;
      flush_xb       <= flush_d;
      stall_fetch    <= stall_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
      epc_we         <= we_d;
      epc_out        <= epc_d;
      cause_we       <= we_d;
      cause_out      <= cause_d;
      tval_we        <= we_d;
      tval_out       <= tval_d;
      in_handler     <= inh_d;
      halted         <= halted_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed vector table plus reset-abort and nested-trap sequences.
// Follows TRAP_SEQ_DOUBLE_FAULT_EN for the nested-trap expectation.
module tb_trap_sequencer;

  localparam logic [6:0] I_ILL  = 7'b1000000;
  localparam logic [6:0] I_MIS  = 7'b0100000;
  localparam logic [6:0] I_MF   = 7'b0010000;
  localparam logic [6:0] I_MS   = 7'b0001000;
  localparam logic [6:0] I_XB   = 7'b0000100;
  localparam logic [6:0] I_MRET = 7'b0000010;
  localparam logic [6:0] I_ACK  = 7'b0000001;

  localparam logic [5:0] O_FL = 6'b100000;
  localparam logic [5:0] O_ST = 6'b010000;
  localparam logic [5:0] O_RV = 6'b001000;
  localparam logic [5:0] O_WE = 6'b000100;
  localparam logic [5:0] O_IH = 6'b000010;
  localparam logic [5:0] O_HL = 6'b000001;

  typedef struct {
    logic [6:0]  fi;
    logic [31:0] fd_pc;
    logic [31:0] xb_pc;
    logic [31:0] inst;
    logic [31:0] maddr;
    logic [31:0] mepc;
    logic [5:0]  fo;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] tval;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetb;
  logic        initiate_illinst;
  logic        initiate_misaligned;
  logic        misaligned_is_fetch;
  logic        misaligned_is_store;
  logic        epc_from_xb;
  logic [31:0] FD_pc;
  logic [31:0] XB_pc;
  logic [31:0] FD_inst;
  logic [31:0] FD_mem_addr;
  logic        mret_req;
  logic [31:0] mepc_in;
  logic        fetch_ack;
  logic        flush_fd;
  logic        flush_xb;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        epc_we;
  logic [31:0] epc_out;
  logic        cause_we;
  logic [31:0] cause_out;
  logic        tval_we;
  logic [31:0] tval_out;
  logic        in_handler;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk                 (clk),
    .resetb              (resetb),
    .initiate_illinst    (initiate_illinst),
    .initiate_misaligned (initiate_misaligned),
    .misaligned_is_fetch (misaligned_is_fetch),
    .misaligned_is_store (misaligned_is_store),
    .epc_from_xb         (epc_from_xb),
    .FD_pc               (FD_pc),
    .XB_pc               (XB_pc),
    .FD_inst             (FD_inst),
    .FD_mem_addr         (FD_mem_addr),
    .mret_req            (mret_req),
    .mepc_in             (mepc_in),
    .fetch_ack           (fetch_ack),
    .flush_fd            (flush_fd),
    .flush_xb            (flush_xb),
    .stall_fetch         (stall_fetch),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .epc_we              (epc_we),
    .epc_out             (epc_out),
    .cause_we            (cause_we),
    .cause_out           (cause_out),
    .tval_we             (tval_we),
    .tval_out            (tval_out),
    .in_handler          (in_handler),
    .halted              (halted)
  );

  function automatic void add(
    input logic [6:0]  fi,
    input logic [31:0] fd_pc,
    input logic [31:0] xb_pc,
    input logic [31:0] inst,
    input logic [31:0] maddr,
    input logic [31:0] mepc,
    input logic [5:0]  fo,
    input logic [31:0] rpc,
    input logic [31:0] epc,
    input logic [31:0] cause,
    input logic [31:0] tval
  );
    vec_t v;
    v.fi = fi;     v.fd_pc = fd_pc; v.xb_pc = xb_pc;
    v.inst = inst; v.maddr = maddr; v.mepc = mepc;
    v.fo = fo;     v.rpc = rpc;     v.epc = epc;
    v.cause = cause; v.tval = tval;
    tbl.push_back(v);
  endfunction

  // Simple control-only step: ack or idle with given expected flags
  function automatic void step(
    input logic [6:0]  fi,
    input logic [31:0] mepc,
    input logic [5:0]  fo,
    input logic [31:0] rpc
  );
    add(fi, 0, 0, 0, 0, mepc, fo, rpc, 0, 0, 0);
  endfunction

  function automatic void ack2(input logic [5:0] ih, input logic [31:0] rpc);
    step(I_ACK, 0, O_ST | O_RV | ih, rpc);
    step(I_ACK, 0, ih, rpc);
  endfunction

  task automatic cmp(input string nm, input string sig,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h want %h", nm, sig, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    n_vec++;
    cmp(nm, "flush_fd", 32'(flush_fd), 0);
    cmp(nm, "flush_xb", 32'(flush_xb), 0);
    cmp(nm, "stall_fetch", 32'(stall_fetch), 0);
    cmp(nm, "redirect_valid", 32'(redirect_valid), 0);
    cmp(nm, "redirect_pc", redirect_pc, 0);
    cmp(nm, "epc_we", 32'(epc_we), 0);
    cmp(nm, "epc_out", epc_out, 0);
    cmp(nm, "cause_we", 32'(cause_we), 0);
    cmp(nm, "cause_out", cause_out, 0);
    cmp(nm, "tval_we", 32'(tval_we), 0);
    cmp(nm, "tval_out", tval_out, 0);
    cmp(nm, "in_handler", 32'(in_handler), 0);
    cmp(nm, "halted", 32'(halted), 0);
  endtask

  task automatic apply(input vec_t v);
    initiate_illinst    = v.fi[6];
    initiate_misaligned = v.fi[5];
    misaligned_is_fetch = v.fi[4];
    misaligned_is_store = v.fi[3];
    epc_from_xb         = v.fi[2];
    mret_req            = v.fi[1];
    fetch_ack           = v.fi[0];
    FD_pc               = v.fd_pc;
    XB_pc               = v.xb_pc;
    FD_inst             = v.inst;
    FD_mem_addr         = v.maddr;
    mepc_in             = v.mepc;
  endtask

  task automatic check(input string nm, input vec_t v);
    n_vec++;
    cmp(nm, "flush_fd", 32'(flush_fd), 32'(v.fo[5]));
    cmp(nm, "flush_xb", 32'(flush_xb), 32'(v.fo[5]));
    cmp(nm, "stall_fetch", 32'(stall_fetch), 32'(v.fo[4]));
    cmp(nm, "redirect_valid", 32'(redirect_valid), 32'(v.fo[3]));
    cmp(nm, "redirect_pc", redirect_pc, v.rpc);
    cmp(nm, "epc_we", 32'(epc_we), 32'(v.fo[2]));
    cmp(nm, "cause_we", 32'(cause_we), 32'(v.fo[2]));
    cmp(nm, "tval_we", 32'(tval_we), 32'(v.fo[2]));
    cmp(nm, "in_handler", 32'(in_handler), 32'(v.fo[1]));
    cmp(nm, "halted", 32'(halted), 32'(v.fo[0]));
    if (v.fo[2]) begin
      cmp(nm, "epc_out", epc_out, v.epc);
      cmp(nm, "cause_out", cause_out, v.cause);
      cmp(nm, "tval_out", tval_out, v.tval);
    end
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", nm, i), tbl[i]);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    step(0, 0, 0, 0);
    apply(tbl[0]);
    tbl.delete();
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    resetb = 1'b0;
    do_reset();

    // Main table, continuous from reset
    step(0, 0, 0, 0);
    add(I_ILL | I_XB, 32'h55, 32'h100, 32'hFFFF_FFFF, 0, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h100, 2, 32'hFFFF_FFFF);
    step(I_ACK, 0, O_ST | O_RV | O_IH, 32'h4);
    step(I_ILL, 0, O_ST | O_RV | O_IH, 32'h4);
    step(I_ACK, 0, O_IH, 32'h4);
    step(I_MRET, 32'h10A, O_FL | O_ST, 32'h108);
    for (int k = 0; k < 5; k++) step(0, 0, O_ST | O_RV, 32'h108);
    step(I_ACK, 0, 0, 32'h108);
    add(I_MIS | I_MS, 32'h20, 32'h999, 0, 32'h203, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h20, 6, 32'h203);
    ack2(O_IH, 32'h4);
    step(I_MRET | I_ACK, 32'h200, O_FL | O_ST, 32'h200);
    ack2(0, 32'h200);
    add(I_ILL | I_MIS | I_MRET, 32'h43, 0, 32'h1234_5678, 32'hBAD, 32'h300,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h40, 2, 32'h1234_5678);
    ack2(O_IH, 32'h4);
    step(I_MRET, 32'h7, O_FL | O_ST, 32'h4);
    ack2(0, 32'h4);
    add(I_MIS, 32'h60, 0, 0, 32'h61, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h60, 4, 32'h61);
    ack2(O_IH, 32'h4);
    step(I_MRET, 32'h0, O_FL | O_ST, 32'h0);
    ack2(0, 32'h0);
    add(I_MIS | I_MF | I_MS, 32'h80, 0, 0, 32'h82, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h80, 0, 32'h82);
    ack2(O_IH, 32'h4);
    run_tbl("tbl");

    // Nested trap while in_handler=1
`ifdef TRAP_SEQ_DOUBLE_FAULT_EN
    add(I_ILL, 32'h1C4, 0, 32'hDEAD, 0, 0,
        O_FL | O_ST | O_IH | O_HL, 32'h4, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step(I_ACK | I_MRET, 32'h40, O_FL | O_ST | O_IH | O_HL, 32'h4);
    run_tbl("nested_lock");
`else
    add(I_ILL, 32'h1C4, 0, 32'hDEAD, 0, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h1C4, 2, 32'hDEAD);
    ack2(O_IH, 32'h4);
    run_tbl("nested");
`endif

    // Reset abort from REDIRECT
    do_reset();
    add(I_ILL | I_XB, 0, 32'h500, 32'h77, 0, 0,
        O_FL | O_ST | O_WE | O_IH, 32'h4, 32'h500, 2, 32'h77);
    step(0, 0, O_ST | O_RV | O_IH, 32'h4);
    run_tbl("pre_abort");
    #2 resetb = 1'b0;
    #1 check_zero("abort_async");
    @(negedge clk);
    step(0, 0, 0, 0);
    apply(tbl[0]);
    tbl.delete();
    resetb = 1'b1;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    run_tbl("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
